// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pkg
//  Description : Shared SHA-256 constants, padder state encoding and a
//                byte-insert helper for the 512-bit block buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sha256_pkg;

  localparam int BLOCK_W    = 512;
  localparam int LEN_W      = 64;
  localparam int LEN_OFFSET = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_EMIT  = 2'd1,
    S_SPILL = 2'd2,
    S_LAST  = 2'd3
  } padder_state_e;

  // Initial hash value H(0) used by sha256_core.
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constants used by sha256_core.
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Replace byte 'idx' of a block; byte 0 occupies the top 8 bits.
  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                  input logic [5:0]         idx,
                                                  input logic [7:0]         val);
    logic [8:0] sh;
    sh = 9'(BLOCK_W - 8) - {idx, 3'b000};
    return (blk & ~({{(BLOCK_W-8){1'b0}}, 8'hFF} << sh)) |
           ({{(BLOCK_W-8){1'b0}}, val} << sh);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_padder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_padder_if
//  Description : Byte-stream input and 512-bit block output handshakes of
//                the SHA-256 padder. 'master' is the producer/consumer side,
//                'slave' is the padder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sha256_padder_if;
  import sha256_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               in_empty;
  logic               block_valid;
  logic               block_ready;
  logic [BLOCK_W-1:0] block_data;
  logic               block_first;
  logic               block_last;

  modport master (
    output in_valid, in_data, in_last, in_empty, block_ready,
    input  in_ready, block_valid, block_data, block_first, block_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_empty, block_ready,
    output in_ready, block_valid, block_data, block_first, block_last
  );

endinterface
`default_nettype wire

// File: rtl/sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_padder
//  Description : FIPS 180-4 message padder. Packs a byte stream into 512-bit
//                big-endian blocks, appends 0x80, zero fill and the 64-bit
//                bit length, and hands blocks out on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_padder #(
  parameter int BLOCK_W = sha256_pkg::BLOCK_W,
  parameter int LEN_W   = sha256_pkg::LEN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  sha256_padder_if.slave  bus
);
  import sha256_pkg::*;

  localparam logic [6:0] LEN_OFFSET_B = 7'(LEN_OFFSET);
  localparam logic [6:0] BLOCK_BYTES  = 7'(BLOCK_W / 8);

  padder_state_e      state_q, state_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [5:0]         p_q, p_d;        // next free byte in the buffer
  logic [LEN_W-1:0]   cnt_q, cnt_d;    // message bytes accepted so far
  logic               first_q, first_d;
  logic               pend_q, pend_d;  // 0x80 still owed to the next block

  logic               w_has_byte;
  logic [6:0]         w_q;             // first free byte after this beat
  logic [LEN_W-1:0]   w_cnt_beat;      // byte count including this beat
  logic               w_hs;

  assign w_has_byte = ~bus.in_empty;
  assign w_q        = {1'b0, p_q} + {6'd0, w_has_byte};
  assign w_cnt_beat = cnt_q + {{(LEN_W-1){1'b0}}, w_has_byte};
  assign w_hs       = bus.block_valid & bus.block_ready;

  assign bus.in_ready    = (state_q == S_FILL);
  assign bus.block_valid = (state_q != S_FILL);
  assign bus.block_data  = buf_q;
  assign bus.block_first = (state_q != S_FILL) & first_q;
  assign bus.block_last  = (state_q == S_LAST);

  // State and datapath registers; reset discards any partial message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      buf_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: byte packing, padding placement and block hand-off.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    pend_d  = pend_q;
    case (state_q)
      S_FILL: begin
        // An empty beat is only meaningful as a terminator.
        if (bus.in_valid && (bus.in_last || w_has_byte)) begin
          if (w_has_byte) begin
            buf_d = put_byte(buf_q, p_q, bus.in_data);
            p_d   = p_q + 6'd1;
            cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
          end
          if (bus.in_last) begin
            if (w_q < LEN_OFFSET_B) begin
              buf_d              = put_byte(buf_d, w_q[5:0], PAD_BYTE);
              buf_d[LEN_W-1:0]   = w_cnt_beat << 3;
              state_d            = S_LAST;
            end else if (w_q < BLOCK_BYTES) begin
              buf_d   = put_byte(buf_d, w_q[5:0], PAD_BYTE);
              state_d = S_SPILL;
            end else begin
              pend_d  = 1'b1;
              state_d = S_SPILL;
            end
          end else if (p_q == 6'd63) begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (w_hs) begin
          buf_d   = '0;
          p_d     = '0;
          first_d = 1'b0;
          state_d = S_FILL;
        end
      end
      S_SPILL: begin
        // The trailing block carries only the length, plus 0x80 when the
        // message ended exactly on a block boundary.
        if (w_hs) begin
          buf_d = '0;
          if (pend_q) buf_d = put_byte(buf_d, 6'd0, PAD_BYTE);
          buf_d[LEN_W-1:0] = cnt_q << 3;
          first_d = 1'b0;
          pend_d  = 1'b0;
          state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (w_hs) begin
          buf_d   = '0;
          p_d     = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          pend_d  = 1'b0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_padder
//  Description : Randomized self-checking bench for sha256_padder against a
//                queue-based FIPS 180-4 padding model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_padder;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  localparam int LIMIT = 300;

  logic clk;
  logic rst_n;
  bit   hold_ready;
  int   errors;
  int   checks;
  blk_t exp_q[$];

  sha256_padder_if bus();

  sha256_padder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: standard padding of the whole message, then cut into blocks.
  task automatic push_expected(input byte_q_t msg);
    byte_q_t      p;
    logic [63:0]  bits;
    blk_t         b;
    int           nblk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int k = 0; k < nblk; k++) begin
      b.data = '0;
      for (int i = 0; i < 64; i++) b.data[511 - 8*i -: 8] = p[64*k + i];
      b.first = (k == 0);
      b.last  = (k == nblk - 1);
      exp_q.push_back(b);
    end
  endtask

  // Entered and left on a negedge; the beat is taken at the posedge between.
  task automatic drive_beat(input logic [7:0] d, input logic last, input logic empty);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_empty = empty;
    guard = 0;
    while (!bus.in_ready && guard < LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= LIMIT) chk("beat_timeout", {511'd0, bus.in_ready}, 512'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic send_msg(input byte_q_t msg, input bit empty_term);
    int n;
    bit et;
    n  = msg.size();
    et = empty_term || (n == 0);
    push_expected(msg);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        bus.in_valid = 1'b1; bus.in_empty = 1'b1; bus.in_last = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.in_empty = 1'b0;
      end
      drive_beat(msg[i], !et && (i == n - 1), 1'b0);
    end
    if (et) drive_beat(8'h00, 1'b1, 1'b1);
    chk("valid_after_term", {511'd0, bus.block_valid}, 512'd1);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4 * LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4 * LIMIT) chk("drain_timeout", 512'(exp_q.size()), 512'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},    {511'd0, bus.in_ready},    512'd1);
    chk({tag, "_valid"},       {511'd0, bus.block_valid}, 512'd0);
    chk({tag, "_data"},        bus.block_data,            512'd0);
    chk({tag, "_first"},       {511'd0, bus.block_first}, 512'd0);
    chk({tag, "_last"},        {511'd0, bus.block_last},  512'd0);
  endtask

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t m;
    for (int i = 0; i < len; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  // Consumer: randomly ready, scores every handshaken block.
  initial begin
    blk_t e;
    bit   r;
    bus.block_ready = 1'b0;
    forever begin
      @(negedge clk);
      r = !hold_ready && rst_n && ($urandom_range(0, 3) != 0);
      bus.block_ready = r;
      if (r && bus.block_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_block", {511'd0, bus.block_valid}, 512'd0);
        end else begin
          e = exp_q.pop_front();
          chk("block_data",  bus.block_data,            e.data);
          chk("block_first", {511'd0, bus.block_first}, {511'd0, e.first});
          chk("block_last",  {511'd0, bus.block_last},  {511'd0, e.last});
        end
      end
    end
  end

  initial begin
    byte_q_t m;
    errors       = 0;
    checks       = 0;
    hold_ready   = 1'b0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // "abc"
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_drain();

    // Empty message
    m = {};
    send_msg(m, 1'b1);
    wait_drain();

    // 55 bytes of 'A': 0x80 and length fit in one block
    m = {};
    repeat (55) m.push_back(8'h41);
    send_msg(m, 1'b0);
    wait_drain();

    // 56 bytes: padding spills into a second block
    m = rand_msg(56);
    send_msg(m, 1'b0);
    wait_drain();

    // 64 bytes terminated by an empty beat, then with last on byte 64
    m = rand_msg(64);
    send_msg(m, 1'b1);
    wait_drain();
    send_msg(m, 1'b0);
    wait_drain();

    // Backpressure: the first of two blocks is held for 10 cycles
    hold_ready = 1'b1;
    m = rand_msg(56);
    send_msg(m, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data",     bus.block_data,            exp_q[0].data);
      chk("hold_first",    {511'd0, bus.block_first}, {511'd0, exp_q[0].first});
      chk("hold_last",     {511'd0, bus.block_last},  {511'd0, exp_q[0].last});
      chk("hold_in_ready", {511'd0, bus.in_ready},    512'd0);
    end
    hold_ready = 1'b0;
    wait_drain();

    // Reset mid-message, then "abc" must come out clean
    for (int i = 0; i < 20; i++) drive_beat(8'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0);
    wait_drain();

    // Random lengths, including block-boundary cases
    for (int t = 0; t < 16; t++) begin
      int len;
      len = (t % 4 == 0) ? 64 * int'($urandom_range(0, 2)) : int'($urandom_range(0, 140));
      m = rand_msg(len);
      send_msg(m, $urandom_range(0, 1) == 1);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    chk("leftover_blocks", 512'(exp_q.size()), 512'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha256_padder.md
# sha256_padder

Message padder and block framer feeding `sha256_core`. Accepts an arbitrary-length byte stream per message, applies FIPS 180-4 padding (0x80, zero fill, 64-bit big-endian bit length), and presents completed 512-bit blocks on a valid/ready interface. Block layout matches `block_in` of `sha256_core`: the first message byte is in bits [511:504].

## Interface
Parameters:
- BLOCK_W, 512, block width; fixed, not overridable in practice.
- LEN_W, 64, width of the appended bit-length field.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  padder accepts a byte this cycle.
- in_data  in  8  message byte.
- in_last  in  1  final beat of message.
- in_empty  in  1  qualifies an `in_last` beat as carrying no byte; used for empty messages and for terminating on a 64-byte boundary.
- block_valid  out  1  `block_data` holds a complete block.
- block_ready  in  1  consumer takes the block.
- block_data  out  512  padded block, big-endian byte order.
- block_first  out  1  block is the first block of its message.
- block_last  out  1  block is the final block; the consumer reads the digest after it.

## Operation
- Clock and reset: one clock. Reset is asynchronous and active-low.
- States:
  - S_FILL: accept bytes.
  - S_EMIT: present a full data block.
  - S_SPILL: present a padded block with no room for the length field.
  - S_LAST: present the final block.
- Reset values: state S_FILL, `block_valid` 0, `block_data` 0, `block_first` 0, `block_last` 0, byte index 0, byte count 0, first flag 1, pending-0x80 flag 0. `in_ready` = (state == S_FILL), so it reads 1 out of reset.
- S_FILL, byte accepted (in_valid & in_ready & !in_empty):
  - Write the byte at index p.
  - Increment p and the byte count.
- Accepted byte with !in_last and p == 63: go to S_EMIT.
- Terminating beat, with q = index of the first free byte after the beat:
  - q ≤ 55: write 0x80 at q and the length in bytes 56..63. Go to S_LAST.
  - 56 ≤ q ≤ 63: write 0x80 at q. Go to S_SPILL.
  - q == 64 (the last byte filled the block): set pending-0x80. Go to S_SPILL with no 0x80 in this block.
- Length field = byte count × 8, mod 2^64. It includes the byte on the terminating beat.
- Emit states:
  - `block_valid` = 1. `block_first` = first flag. `block_last` = 1 only in S_LAST.
  - Outputs are held stable until block_ready.
- Handshake from S_EMIT: clear the buffer, p = 0, clear the first flag, go to S_FILL.
- Handshake from S_SPILL:
  - Load the buffer with zeros plus the length field, and 0x80 at byte 0 if pending-0x80.
  - Clear the first flag. Go to S_LAST.
- Handshake from S_LAST: clear the buffer, byte count and p. Set the first flag. Go to S_FILL.
- The buffer is zeroed on every handshake, so padding zeros are implicit.
- in_valid is ignored outside S_FILL.
- in_empty without in_last is illegal. The padder ignores that beat and does not accept it.
- Reset mid-message or mid-emit: the partial message is discarded and all state returns to reset values immediately.

## Timing
- One byte per cycle in S_FILL.
- `block_valid` rises the cycle after the 64th byte or the terminating beat is accepted.
- S_SPILL → S_LAST: the next block is presented the cycle after the handshake. `block_valid` stays 1 throughout (back-to-back).
- `in_ready` is 0 from the cycle after the block completes until the cycle after the emit handshake.
- Throughput ceiling: 64 bytes per 65 cycles.

## Structure
- Shared package `sha256_pkg`:
  - BLOCK_W, LEN_W, PAD_BYTE (8'h80), LEN_OFFSET (56).
  - Padder state enum.
- The same package also holds the IV and K constants used by `sha256_core`.
- No sub-module. Buffer, counters and FSM live in one module.

## Test plan
- "abc" (3 bytes, in_last on 0x63):
  - One block, first=last=1.
  - block_data = 61626380 followed by fourteen zero words, then 00000018.
- Empty message (single in_last & in_empty beat):
  - One block 80000000, then 0…0, with length 0.
  - first=last=1.
- 55 bytes of 0x41:
  - One block; byte 55 = 0x80; length 0x1B8.
- 56 bytes:
  - Block 1: 0x80 at byte 56, no length; first=1, last=0.
  - Block 2: all zero except length 0x1C0; first=0, last=1.
- 64 bytes, then an in_last & in_empty beat:
  - Block 1: data only.
  - Block 2: 0x80 at byte 0, length 0x200.
- Holding 64 bytes with in_last on byte 64 gives the same result as the previous case.
- Backpressure: block_ready held 0 for 10 cycles:
  - block_data, first and last are stable; in_ready = 0.
- Reset mid-message: rst_n asserted after 20 bytes, then "abc" sent:
  - Output matches the "abc" case exactly.
